// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and the response-register state type.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_MAX = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_t;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational 32-bit ALU. Opcodes above ALU_OP_MAX produce 0; the illegal
// flag is decoded only when ALU_ARB_ILLEGAL_OP_EN is defined, otherwise it is tied low.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]            op_i,
  input  logic [ALU_DATA_W-1:0] a_i,
  input  logic [ALU_DATA_W-1:0] b_i,
  output logic [ALU_DATA_W-1:0] result_o,
  output logic                  illegal_o
);

  always_comb begin
    result_o = '0;
    case (alu_op_t'(op_i))
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      // Unsigned compare, zero-extended single-bit result.
      ALU_SLT: result_o = {{(ALU_DATA_W-1){1'b0}}, (a_i < b_i)};
      default: result_o = '0;
    endcase
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign illegal_o = (op_i > 4'(ALU_OP_MAX));
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from rr_ptr, grants the first active request and
// moves the pointer past the winner only when the caller reports the grant was taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o,
  output logic [IDX_W-1:0]   rr_ptr_o
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;

  always_comb begin
    int j;
    j           = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IDX_W'(j);
      end
    end
  end

  assign rr_ptr_d = (adv_i && any_o) ?
                    ((int'(grant_idx_o) == NUM_REQ - 1) ? '0 : grant_idx_o + IDX_W'(1)) :
                    rr_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and a single
// registered response slot. ALU_ARB_ILLEGAL_OP_EN enables the resp_err illegal-opcode flag.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*4-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready may depend on req_valid and resp_ready in the same cycle; resp_* stay
  // stable while resp_valid is high and resp_ready is low.

  resp_state_t       state_q;
  logic [DATA_W-1:0] data_q;
  logic [ID_W-1:0]   id_q;
  logic              err_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    rr_ptr;
  logic               grant_any;
  logic               can_accept;
  logic               accept;

  logic [3:0]        op_sel;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ill;

  assign can_accept = ((state_q == RESP_EMPTY) | resp_ready) & ~reset;
  assign accept     = can_accept & grant_any;
  assign req_ready  = can_accept ? grant : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .adv_i       (can_accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any),
    .rr_ptr_o    (rr_ptr)
  );

  always_comb begin
    ptr_in_range: assert (int'(rr_ptr) < NUM_REQ);
  end

  assign op_sel = req_op[int'(grant_idx)*4 +: 4];
  assign a_sel  = req_a[int'(grant_idx)*DATA_W +: DATA_W];
  assign b_sel  = req_b[int'(grant_idx)*DATA_W +: DATA_W];

  alu u_alu (
    .op_i      (op_sel),
    .a_i       (a_sel),
    .b_i       (b_sel),
    .result_o  (alu_res),
    .illegal_o (alu_ill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESP_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      state_q <= RESP_FULL;
      data_q  <= alu_res;
      id_q    <= grant_idx;
      err_q   <= alu_ill;
    end else if (resp_ready) begin
      // Draining keeps the last payload visible; only the valid flag clears.
      state_q <= RESP_EMPTY;
    end
  end

  assign resp_valid = (state_q == RESP_FULL);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's single-cycle 32-bit ALU between NUM_REQ independent requesters.
- Arbitration is round-robin. Each request is a valid/ready transaction carrying a 4-bit ALU opcode and two operands.
- Each result is registered once and returned on a shared response channel, tagged with the requester index and held under backpressure.
- Sits between issue/sequencer logic and the ALU datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width; fixed to 32 while the shared ALU is 32-bit.
- ID_W, $clog2(NUM_REQ), width of resp_id.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_op  in  NUM_REQ*4  packed opcodes; requester i at [4i+3:4i]
- req_a  in  NUM_REQ*DATA_W  packed operand1, requester i at [DATA_W*i +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed operand2, same packing as req_a
- resp_valid  out  1  response held valid
- resp_ready  in  1  consumer accepts response
- resp_id  out  ID_W  index of the requester that produced the response
- resp_data  out  DATA_W  ALU result
- resp_err  out  1  illegal opcode flag; tied 0 unless ALU_ARB_ILLEGAL_OP_EN is defined

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5. Any other opcode returns result 0.
- ADD/SUB wrap modulo 2^32. SLT is an unsigned compare, giving 32'd1 or 32'd0.
- The ALU is used purely combinationally. Operands are muxed from the granted requester and must be stable in the accept cycle only.
- Output register state machine, two states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- can_accept = (state==EMPTY) | resp_ready.
- Arbitration:
  - The search starts at rr_ptr and scans upward modulo NUM_REQ. The first i with req_valid[i]=1 is granted.
  - req_ready[i] = can_accept & grant[i]. req_ready depends combinationally on req_valid and resp_ready; this is permitted.
- Accept (req_valid[i] & req_ready[i]) in cycle T:
  - At the T clock edge, resp_data, resp_id and resp_err load, and state goes to FULL.
  - rr_ptr becomes (i+1) mod NUM_REQ.
  - resp_valid is first high in T+1. Latency is 1 cycle.
- In FULL with resp_ready=1 and no accept: state goes to EMPTY. resp_data and resp_id keep their old values.
- In FULL with resp_ready=1 and an accept in the same cycle: the register reloads and state stays FULL. Throughput is 1 op/cycle.
- In FULL with resp_ready=0: all response outputs are held stable, every req_ready bit is 0, and rr_ptr is unchanged.
- No req_valid asserted: rr_ptr is unchanged.
- A requester that drops req_valid without a handshake is not recorded; no state is kept per requester.
- Reset, asynchronous and usable mid-transaction:
  - state=EMPTY, resp_valid=0, resp_data=0, resp_id=0, resp_err=0, rr_ptr=0.
  - Any in-flight response is discarded.
  - req_ready is 0 while reset is asserted.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_OP_EN.
- Defined:
  - An accepted opcode >5 loads resp_err=1 with resp_data=0.
  - The response still returns normally and must be consumed.
- Undefined:
  - resp_err is tied 0 and no opcode decode logic is built.
  - Illegal opcodes silently return 0.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t, a 4-bit enum with ADD..SLT.
  - ALU_OP_MAX=5.
  - ALU_DATA_W=32.
- Both the ALU and alu_arbiter import alu_pkg.
- Sub-module rr_arbiter holds the round-robin logic:
  - Parameter: NUM_REQ.
  - Ports: req vector, enable (advance), grant one-hot, grant index, rr_ptr state.
- alu_arbiter instantiates rr_arbiter and the ALU.

Test Plan:
- Single request: requester 2, op=ADD, a=0xFFFF_FFFF, b=2. Expect req_ready[2]=1 the same cycle; next cycle resp_valid=1, resp_id=2, resp_data=0x0000_0001.
- All 4 requesters valid continuously, resp_ready=1: grants in order 0,1,2,3,0; one response per cycle; no gaps; resp_id sequence matches.
- Backpressure:
  - Setup: requester 1 issues SUB 5-7. Hold resp_ready=0 for 5 cycles with requester 0 valid.
  - Expect resp_data=0xFFFF_FFFE held; req_ready=0 throughout.
  - On release: requester 0 is accepted in the drain cycle.
- SLT and logic ops: SLT 3,0x8000_0000 gives 1; XOR 0xF0F0,0xFF00 gives 0x0FF0; AND, OR checked likewise.
- Illegal op=9 with a=b=1:
  - Macro defined: resp_data=0, resp_err=1.
  - Macro undefined: resp_data=0, resp_err=0.
- Reset asserted while FULL: resp_valid drops asynchronously with outputs 0. After release, the first grant goes to requester 0 when all are valid.
